// File: rtl/wash_pkg.sv
// Shared types, programme timing and display codes for the washing-machine sequencer.
package wash_pkg;

    localparam int unsigned DISP_W   = 6;
    localparam int unsigned WAT_FULL = 4;
    localparam int unsigned WASH_T   = 10;
    localparam int unsigned RINSE_T  = 6;
    localparam int unsigned SPIN_T   = 5;
    localparam int unsigned LAMP_T   = 2;
    localparam int unsigned LAMP_W   = $clog2(LAMP_T + 1);

    localparam int unsigned WASH_LEN  = 2 * WAT_FULL + WASH_T;
    localparam int unsigned RINSE_LEN = 2 * WAT_FULL + RINSE_T;
    localparam int unsigned SPIN_LEN  = SPIN_T;
    localparam int unsigned PROG_MAX  = WASH_LEN + RINSE_LEN + SPIN_LEN;
    localparam int unsigned DISP_MAX  = 54;

    localparam logic [DISP_W-1:0] DISP_BLANK = DISP_W'(55);
    localparam logic [DISP_W-1:0] DISP_LAMP  = DISP_W'(56);

    localparam logic [1:0] MOTOR_OFF     = 2'b00;
    localparam logic [1:0] MOTOR_AGITATE = 2'b01;
    localparam logic [1:0] MOTOR_SPIN    = 2'b10;

    typedef enum logic [2:0] {LAMP, IDLE, RUN, PAUSE, DONE} state_e;
    typedef enum logic [1:0] {WASH, RINSE, SPIN} phase_e;
    typedef enum logic [1:0] {STEP_FILL, STEP_AGITATE, STEP_DRAIN, STEP_SPIN} step_e;

    function automatic logic [DISP_W-1:0] phaseLen(phase_e ph);
        case (ph)
            WASH:    return DISP_W'(WASH_LEN);
            RINSE:   return DISP_W'(RINSE_LEN);
            default: return DISP_W'(SPIN_LEN);
        endcase
    endfunction

    function automatic logic [DISP_W-1:0] totalLen(logic [2:0] mode);
        return (mode[0] ? DISP_W'(WASH_LEN)  : DISP_W'(0))
             + (mode[1] ? DISP_W'(RINSE_LEN) : DISP_W'(0))
             + (mode[2] ? DISP_W'(SPIN_LEN)  : DISP_W'(0));
    endfunction

    function automatic phase_e firstPhase(logic [2:0] mode);
        if (mode[0])      return WASH;
        else if (mode[1]) return RINSE;
        else              return SPIN;
    endfunction

    // Sub-step is derived from the remaining count: fill at the top, drain at the bottom.
    function automatic step_e stepOf(phase_e ph, logic [DISP_W-1:0] cur);
        logic [DISP_W-1:0] len;
        step_e             st;
        len = phaseLen(ph);
        if (ph == SPIN)                           st = STEP_SPIN;
        else if (cur > len - DISP_W'(WAT_FULL))   st = STEP_FILL;
        else if (cur > DISP_W'(WAT_FULL))         st = STEP_AGITATE;
        else                                      st = STEP_DRAIN;
        return st;
    endfunction

endpackage

// File: rtl/wash_phase_counter.sv
// Loadable down counter for the current-phase remaining ticks; flags the final tick.
module wash_phase_counter #(
    parameter int unsigned     W       = 6,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         uRst_,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         isLast_c
);

    always_ff @(posedge clk or negedge uRst_) begin
        if (!uRst_)                  count <= RST_VAL;
        else if (load)               count <= loadVal;
        else if (en && count != '0)  count <= count - W'(1);
    end

    assign isLast_c = (count == W'(1));

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine programme controller: sequences WASH/RINSE/SPIN from 1 Hz ticks.
module wash_sequencer
    import wash_pkg::*;
(
    input  logic              clk,
    input  logic              uRst_,
    input  logic              uTick,
    input  logic              uStart,
    input  logic              uPause,
    input  logic [2:0]        uMode,
    output logic [DISP_W-1:0] yTot,
    output logic [DISP_W-1:0] yCur,
    output logic [DISP_W-1:0] yWat,
    output logic              yInlet,
    output logic              yDrain,
    output logic [1:0]        yMotor,
    output logic              yDone,
    output logic              yPaused
);

    if (PROG_MAX > DISP_MAX) begin : gCfgCheck
        $error("wash_sequencer: programme length exceeds display range");
    end

    state_e              state, nxtState;
    phase_e              phase, nxtPhase;
    logic [LAMP_W-1:0]   lampCnt, nxtLamp;
    logic [2:0]          modeLat, nxtMode;
    logic [DISP_W-1:0]   nxtTot, nxtWat, nxtCur, curLoadVal;
    logic                curLoad, curEn, curLast;
    logic [2:0]          laterMask;
    step_e               nxtStep;
    logic                nxtInlet, nxtDrain;
    logic [1:0]          nxtMotor;

    wash_phase_counter #(.W(DISP_W), .RST_VAL(DISP_LAMP)) uCurCnt (
        .clk      (clk),
        .uRst_    (uRst_),
        .load     (curLoad),
        .loadVal  (curLoadVal),
        .en       (curEn),
        .count    (yCur),
        .isLast_c (curLast)
    );

    always_ff @(posedge clk or negedge uRst_) begin
        if (!uRst_) begin
            state   <= LAMP;
            phase   <= WASH;
            lampCnt <= LAMP_W'(LAMP_T);
            modeLat <= '0;
            yTot    <= DISP_LAMP;
            yWat    <= DISP_LAMP;
            yInlet  <= 1'b0;
            yDrain  <= 1'b0;
            yMotor  <= MOTOR_OFF;
            yDone   <= 1'b0;
            yPaused <= 1'b0;
        end else begin
            state   <= nxtState;
            phase   <= nxtPhase;
            lampCnt <= nxtLamp;
            modeLat <= nxtMode;
            yTot    <= nxtTot;
            yWat    <= nxtWat;
            yInlet  <= nxtInlet;
            yDrain  <= nxtDrain;
            yMotor  <= nxtMotor;
            yDone   <= (nxtState == DONE);
            yPaused <= (nxtState == PAUSE);
        end
    end

    // Next-state and counter control; events not listed for a state are ignored.
    always_comb begin
        nxtState   = state;
        nxtPhase   = phase;
        nxtLamp    = lampCnt;
        nxtMode    = modeLat;
        nxtTot     = yTot;
        nxtWat     = yWat;
        curLoad    = 1'b0;
        curLoadVal = yCur;
        curEn      = 1'b0;
        laterMask  = '0;
        case (phase)
            WASH:    laterMask = modeLat & 3'b110;
            RINSE:   laterMask = modeLat & 3'b100;
            default: laterMask = '0;
        endcase

        case (state)
            LAMP: begin
                if (uTick) begin
                    if (lampCnt != '0) nxtLamp = lampCnt - LAMP_W'(1);
                    if (lampCnt <= LAMP_W'(1)) begin
                        nxtState   = IDLE;
                        nxtTot     = totalLen(uMode);
                        nxtWat     = DISP_BLANK;
                        curLoad    = 1'b1;
                        curLoadVal = DISP_BLANK;
                    end
                end
            end
            IDLE: begin
                nxtTot     = totalLen(uMode);
                nxtWat     = DISP_BLANK;
                curLoad    = 1'b1;
                curLoadVal = DISP_BLANK;
                if (uStart && uMode != 3'b000) begin
                    nxtState   = RUN;
                    nxtMode    = uMode;
                    nxtPhase   = firstPhase(uMode);
                    nxtWat     = '0;
                    curLoadVal = phaseLen(firstPhase(uMode));
                end
            end
            RUN: begin
                if (uPause) begin
                    nxtState = PAUSE;
                end else if (uTick) begin
                    if (yTot != '0) nxtTot = yTot - DISP_W'(1);
                    curEn = 1'b1;
                    case (stepOf(phase, yCur))
                        STEP_FILL:  nxtWat = yWat + DISP_W'(1);
                        STEP_DRAIN: if (yWat != '0) nxtWat = yWat - DISP_W'(1);
                        default:    nxtWat = yWat;
                    endcase
                    if (curLast) begin
                        curLoad = 1'b1;
                        if (laterMask[1]) begin
                            nxtPhase   = RINSE;
                            curLoadVal = phaseLen(RINSE);
                        end else if (laterMask[2]) begin
                            nxtPhase   = SPIN;
                            curLoadVal = phaseLen(SPIN);
                        end else begin
                            nxtState   = DONE;
                            nxtTot     = '0;
                            nxtWat     = '0;
                            curLoadVal = DISP_BLANK;
                        end
                    end
                end
            end
            PAUSE: begin
                if (uPause) nxtState = RUN;
            end
            DONE: begin
                if (uStart) begin
                    nxtState   = IDLE;
                    nxtTot     = totalLen(uMode);
                    nxtWat     = DISP_BLANK;
                    curLoad    = 1'b1;
                    curLoadVal = DISP_BLANK;
                end
            end
            default: nxtState = LAMP;
        endcase
    end

    // Actuators follow the counts they will be registered alongside.
    always_comb begin
        nxtInlet = 1'b0;
        nxtDrain = 1'b0;
        nxtMotor = MOTOR_OFF;
        if (curLoad)                     nxtCur = curLoadVal;
        else if (curEn && yCur != '0)    nxtCur = yCur - DISP_W'(1);
        else                             nxtCur = yCur;
        nxtStep = stepOf(nxtPhase, nxtCur);
        if (nxtState == RUN) begin
            case (nxtStep)
                STEP_FILL:    nxtInlet = 1'b1;
                STEP_AGITATE: nxtMotor = MOTOR_AGITATE;
                STEP_DRAIN:   nxtDrain = 1'b1;
                default: begin
                    nxtMotor = MOTOR_SPIN;
                    nxtDrain = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wash_sequencer.sv
// Directed checks of the washing-machine sequencer against hand-computed values.
module tb_wash_sequencer;

    logic       clk = 1'b0;
    logic       uRst_;
    logic       uTick, uStart, uPause;
    logic [2:0] uMode;
    logic [5:0] yTot, yCur, yWat;
    logic       yInlet, yDrain, yDone, yPaused;
    logic [1:0] yMotor;

    int nChecks = 0;
    int nFail   = 0;

    wash_sequencer dut (
        .clk     (clk),
        .uRst_   (uRst_),
        .uTick   (uTick),
        .uStart  (uStart),
        .uPause  (uPause),
        .uMode   (uMode),
        .yTot    (yTot),
        .yCur    (yCur),
        .yWat    (yWat),
        .yInlet  (yInlet),
        .yDrain  (yDrain),
        .yMotor  (yMotor),
        .yDone   (yDone),
        .yPaused (yPaused)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs != exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given pulses; returns at the following falling edge.
    task automatic step(input logic t, input logic s, input logic p);
        @(negedge clk);
        uTick  = t;
        uStart = s;
        uPause = p;
        @(negedge clk);
        uTick  = 1'b0;
        uStart = 1'b0;
        uPause = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        uRst_  = 1'b0;
        uTick  = 1'b0;
        uStart = 1'b0;
        uPause = 1'b0;
        uMode  = 3'b111;
        repeat (2) @(negedge clk);
        uRst_ = 1'b1;

        checkEq("rst_tot", yTot, 56);
        checkEq("rst_cur", yCur, 56);
        checkEq("rst_wat", yWat, 56);
        checkEq("rst_act", {yInlet, yDrain, yMotor, yDone, yPaused}, 0);

        ticks(1);
        checkEq("lamp1_tot", yTot, 56);
        ticks(1);
        checkEq("idle_tot", yTot, 37);
        checkEq("idle_cur", yCur, 55);
        checkEq("idle_wat", yWat, 55);

        uMode = 3'b011;
        step(1'b0, 1'b0, 1'b0);
        checkEq("idle_live_tot", yTot, 32);
        uMode = 3'b111;

        step(1'b0, 1'b1, 1'b0);
        checkEq("start_tot", yTot, 37);
        checkEq("start_cur", yCur, 18);
        checkEq("start_wat", yWat, 0);
        checkEq("start_inlet", yInlet, 1);

        ticks(4);
        checkEq("fill_wat", yWat, 4);
        checkEq("fill_inlet", yInlet, 0);
        checkEq("agit_motor", yMotor, 1);
        checkEq("agit_cur", yCur, 14);
        checkEq("agit_tot", yTot, 33);

        ticks(10);
        checkEq("drain_cur", yCur, 4);
        checkEq("drain_valve", yDrain, 1);
        checkEq("drain_motor", yMotor, 0);
        checkEq("drain_wat", yWat, 4);

        ticks(4);
        checkEq("rinse_cur", yCur, 14);
        checkEq("rinse_tot", yTot, 19);
        checkEq("rinse_wat", yWat, 0);
        checkEq("rinse_inlet", yInlet, 1);

        step(1'b0, 1'b1, 1'b0);
        checkEq("run_start_tot", yTot, 19);
        checkEq("run_start_cur", yCur, 14);

        ticks(2);
        checkEq("midrinse_tot", yTot, 17);
        uRst_ = 1'b0;
        #1;
        checkEq("async_tot", yTot, 56);
        checkEq("async_cur", yCur, 56);
        checkEq("async_wat", yWat, 56);
        checkEq("async_inlet", yInlet, 0);
        @(negedge clk);
        uRst_ = 1'b1;

        ticks(1);
        checkEq("relamp_tot", yTot, 56);
        ticks(1);
        checkEq("reidle_tot", yTot, 37);

        step(1'b0, 1'b1, 1'b0);
        ticks(7);
        checkEq("pre_pause_tot", yTot, 30);
        step(1'b1, 1'b0, 1'b1);
        checkEq("pause_flag", yPaused, 1);
        checkEq("pause_tot", yTot, 30);
        checkEq("pause_cur", yCur, 11);
        checkEq("pause_motor", yMotor, 0);
        ticks(3);
        checkEq("pause_hold_tot", yTot, 30);
        step(1'b0, 1'b0, 1'b1);
        checkEq("resume_flag", yPaused, 0);
        checkEq("resume_motor", yMotor, 1);
        ticks(1);
        checkEq("resume_tick_tot", yTot, 29);

        ticks(29);
        checkEq("done_flag", yDone, 1);
        checkEq("done_tot", yTot, 0);
        checkEq("done_cur", yCur, 55);
        checkEq("done_wat", yWat, 0);
        step(1'b0, 1'b0, 1'b1);
        checkEq("done_pause_ign", yPaused, 0);

        uMode = 3'b100;
        step(1'b0, 1'b1, 1'b0);
        checkEq("done_to_idle_tot", yTot, 5);
        checkEq("done_to_idle_flag", yDone, 0);
        step(1'b0, 1'b1, 1'b0);
        checkEq("spin_cur", yCur, 5);
        checkEq("spin_motor", yMotor, 2);
        checkEq("spin_drain", yDrain, 1);
        ticks(4);
        checkEq("spin4_motor", yMotor, 2);
        checkEq("spin4_drain", yDrain, 1);
        checkEq("spin4_cur", yCur, 1);
        ticks(1);
        checkEq("spin_done", yDone, 1);
        checkEq("spin_done_tot", yTot, 0);
        checkEq("spin_done_cur", yCur, 55);
        checkEq("spin_done_motor", yMotor, 0);
        step(1'b0, 1'b1, 1'b0);
        checkEq("spin_idle_tot", yTot, 5);

        uMode = 3'b000;
        step(1'b0, 1'b1, 1'b0);
        checkEq("nomode_tot", yTot, 0);
        checkEq("nomode_cur", yCur, 55);
        checkEq("nomode_inlet", yInlet, 0);

        uMode = 3'b010;
        step(1'b1, 1'b1, 1'b0);
        checkEq("start_tick_tot", yTot, 14);
        checkEq("start_tick_cur", yCur, 14);
        checkEq("start_tick_inlet", yInlet, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
